// File: rtl/control_unit_if.sv
// Control-unit bundle: datapath status and memory ready lines in,
// register enables, mux selects, ALU opcode and memory strobes out.
interface control_unit_if;
    logic [31:0] iIR;
    logic        iZero;
    logic        iInstrReady;
    logic        iMemReady;
    logic        oIrEn, oRaEn, oRbEn, oRz0En, oRz1En;
    logic        oRloEn, oRmEn, oRyEn, oRpcEn, oRpcTempEn;
    logic        oMbSel, oMincSel, oMpcSel;
    logic [2:0]  oMySel;
    logic [1:0]  oMcSel;
    logic [3:0]  oAluCtl;
    logic        oRfWrite;
    logic        oInstrRead, oMemRead, oMemWrite;
    logic        oHalted, oIllegal;

    modport master (
        input  iIR, iZero, iInstrReady, iMemReady,
        output oIrEn, oRaEn, oRbEn, oRz0En, oRz1En,
        output oRloEn, oRmEn, oRyEn, oRpcEn, oRpcTempEn,
        output oMbSel, oMincSel, oMpcSel, oMySel, oMcSel, oAluCtl,
        output oRfWrite, oInstrRead, oMemRead, oMemWrite,
        output oHalted, oIllegal
    );

    modport slave (
        output iIR, iZero, iInstrReady, iMemReady,
        input  oIrEn, oRaEn, oRbEn, oRz0En, oRz1En,
        input  oRloEn, oRmEn, oRyEn, oRpcEn, oRpcTempEn,
        input  oMbSel, oMincSel, oMpcSel, oMySel, oMcSel, oAluCtl,
        input  oRfWrite, oInstrRead, oMemRead, oMemWrite,
        input  oHalted, oIllegal
    );
endinterface

// File: rtl/control_unit.sv
// Multicycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT.
// Outputs are decoded from the state register and the IR opcode.
module control_unit (
    input  logic           iClk,
    input  logic           iRst,
    control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [4:0] op;
    logic       is_r, is_i, is_ld, is_st, is_md, is_hi, is_lo;
    logic       is_beq, is_jr, is_jal, is_nop, is_halt, legal;
    logic [3:0] alu_op;
    logic       unused_ir;

    assign op        = bus.iIR[31:27];
    assign unused_ir = ^bus.iIR[26:0];

    assign is_r    = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
    assign is_i    = op inside {5'b00111, 5'b01000, 5'b01001};
    assign is_ld   = op == 5'b00000;
    assign is_st   = op == 5'b00010;
    assign is_md   = op inside {5'b01111, 5'b10000};
    assign is_hi   = op == 5'b01010;
    assign is_lo   = op == 5'b01011;
    assign is_beq  = op == 5'b10010;
    assign is_jr   = op == 5'b10011;
    assign is_jal  = op == 5'b10100;
    assign is_nop  = op == 5'b11010;
    assign is_halt = op == 5'b11011;
    assign legal   = is_r | is_i | is_ld | is_st | is_md | is_hi | is_lo |
                     is_beq | is_jr | is_jal | is_nop | is_halt;

    always_comb begin
        unique case (op)
            5'b00100, 5'b10010: alu_op = 4'b0001;
            5'b00101, 5'b01000: alu_op = 4'b0011;
            5'b00110, 5'b01001: alu_op = 4'b0010;
            5'b01111:           alu_op = 4'b0101;
            5'b10000:           alu_op = 4'b0100;
            default:            alu_op = 4'b0000;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        bus.oIrEn      = 1'b0;
        bus.oRaEn      = 1'b0;
        bus.oRbEn      = 1'b0;
        bus.oRz0En     = 1'b0;
        bus.oRz1En     = 1'b0;
        bus.oRloEn     = 1'b0;
        bus.oRmEn      = 1'b0;
        bus.oRyEn      = 1'b0;
        bus.oRpcEn     = 1'b0;
        bus.oRpcTempEn = 1'b0;
        bus.oMbSel     = 1'b0;
        bus.oMincSel   = 1'b0;
        bus.oMpcSel    = 1'b0;
        bus.oMySel     = 3'd0;
        bus.oMcSel     = 2'd0;
        bus.oAluCtl    = 4'b0000;
        bus.oRfWrite   = 1'b0;
        bus.oInstrRead = 1'b0;
        bus.oMemRead   = 1'b0;
        bus.oMemWrite  = 1'b0;
        bus.oHalted    = 1'b0;
        bus.oIllegal   = 1'b0;
        // Reset gates every output so strobes drop without waiting for a clock.
        if (!iRst) begin
            unique case (state_q)
                S_FETCH: begin
                    bus.oInstrRead = 1'b1;
                    if (bus.iInstrReady) begin
                        bus.oIrEn = 1'b1;
                        state_d   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.oRaEn   = 1'b1;
                    bus.oRbEn   = 1'b1;
                    bus.oRpcEn  = 1'b1;
                    bus.oMpcSel = 1'b1;
                    if (!legal) begin
                        bus.oIllegal = 1'b1;
                        state_d      = S_FETCH;
                    end else if (is_halt) begin
                        state_d = S_HALT;
                    end else if (is_nop) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    bus.oRpcTempEn = 1'b1;
                    if (is_r | is_i | is_ld | is_st) begin
                        bus.oAluCtl = alu_op;
                        bus.oRz0En  = 1'b1;
                        bus.oMbSel  = is_i | is_ld | is_st;
                        bus.oRmEn   = is_st;
                    end
                    if (is_md) begin
                        bus.oAluCtl = alu_op;
                        bus.oRz1En  = 1'b1;
                        bus.oRloEn  = 1'b1;
                    end
                    if (is_beq) begin
                        bus.oAluCtl  = alu_op;
                        bus.oRpcEn   = bus.iZero;
                        bus.oMincSel = 1'b1;
                        bus.oMpcSel  = 1'b1;
                    end
                    if (is_jr | is_jal) begin
                        bus.oRpcEn = 1'b1;
                    end
                    if (is_beq | is_jr | is_md) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_MEMORY;
                    end
                end
                S_MEMORY: begin
                    if (is_ld) begin
                        bus.oMemRead = 1'b1;
                        if (bus.iMemReady) begin
                            bus.oRyEn  = 1'b1;
                            bus.oMySel = 3'd2;
                            state_d    = S_WRITEBACK;
                        end
                    end else if (is_st) begin
                        bus.oMemWrite = 1'b1;
                        if (bus.iMemReady) begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        bus.oRyEn = 1'b1;
                        unique case (1'b1)
                            is_hi:   bus.oMySel = 3'd1;
                            is_lo:   bus.oMySel = 3'd3;
                            is_jal:  bus.oMySel = 3'd4;
                            default: bus.oMySel = 3'd0;
                        endcase
                        state_d = S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    bus.oRfWrite = 1'b1;
                    unique case (1'b1)
                        is_jal:               bus.oMcSel = 2'd3;
                        is_r | is_hi | is_lo: bus.oMcSel = 2'd2;
                        default:              bus.oMcSel = 2'd1;
                    endcase
                    state_d = S_FETCH;
                end
                S_HALT: begin
                    bus.oHalted = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle output vectors from an
// instruction-level reference model under random waits and opcodes.
module tb_control_unit;
    typedef struct packed {
        logic ir_en, ra_en, rb_en, rz0_en, rz1_en, rlo_en, rm_en;
        logic ry_en, rpc_en, rpct_en, mb, minc, mpc;
        logic [2:0] my;
        logic [1:0] mc;
        logic [3:0] alu;
        logic rf, ird, mrd, mwr, halted, ill;
    } outs_t;

    typedef struct {
        outs_t e;
        logic  ir;
        logic  mr;
        logic  z;
    } step_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    outs_t  obs;
    step_t  q[$];
    int     checks = 0;
    int     errors = 0;
    string  cur = "init";

    control_unit_if bus ();

    control_unit dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.oIrEn, bus.oRaEn, bus.oRbEn, bus.oRz0En, bus.oRz1En,
                  bus.oRloEn, bus.oRmEn, bus.oRyEn, bus.oRpcEn,
                  bus.oRpcTempEn, bus.oMbSel, bus.oMincSel, bus.oMpcSel,
                  bus.oMySel, bus.oMcSel, bus.oAluCtl, bus.oRfWrite,
                  bus.oInstrRead, bus.oMemRead, bus.oMemWrite,
                  bus.oHalted, bus.oIllegal};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(outs_t e, logic ir, logic mr, logic z);
        step_t s;
        s.e  = e;
        s.ir = ir;
        s.mr = mr;
        s.z  = z;
        q.push_back(s);
    endfunction

    // Expected cycle-by-cycle outputs of one instruction, with the ready
    // and zero inputs the bench will present on each of those cycles.
    task automatic model(input logic [4:0] op, input int fw, input int mw,
                         input logic z);
        outs_t o;
        bit r, i, ld, st, md, hi, lo, beq, jr, jal, nop, hlt, legal;
        logic [3:0] alu;
        r   = op inside {5'd3, 5'd4, 5'd5, 5'd6};
        i   = op inside {5'd7, 5'd8, 5'd9};
        ld  = op == 5'd0;
        st  = op == 5'd2;
        md  = op inside {5'd15, 5'd16};
        hi  = op == 5'd10;
        lo  = op == 5'd11;
        beq = op == 5'd18;
        jr  = op == 5'd19;
        jal = op == 5'd20;
        nop = op == 5'd26;
        hlt = op == 5'd27;
        legal = r | i | ld | st | md | hi | lo | beq | jr | jal | nop | hlt;
        case (op)
            5'd4, 5'd18: alu = 4'd1;
            5'd5, 5'd8:  alu = 4'd3;
            5'd6, 5'd9:  alu = 4'd2;
            5'd15:       alu = 4'd5;
            5'd16:       alu = 4'd4;
            default:     alu = 4'd0;
        endcase
        for (int k = 0; k < fw; k++) begin
            o = '0; o.ird = 1'b1;
            push(o, 1'b0, rb(), rb());
        end
        o = '0; o.ird = 1'b1; o.ir_en = 1'b1;
        push(o, 1'b1, rb(), rb());
        o = '0; o.ra_en = 1'b1; o.rb_en = 1'b1; o.rpc_en = 1'b1;
        o.mpc = 1'b1; o.ill = !legal;
        push(o, rb(), rb(), rb());
        if (!legal || nop) return;
        if (hlt) begin
            for (int k = 0; k < 6; k++) begin
                o = '0; o.halted = 1'b1;
                push(o, rb(), rb(), rb());
            end
            return;
        end
        o = '0; o.rpct_en = 1'b1;
        if (r | i | ld | st) begin
            o.alu = alu; o.rz0_en = 1'b1;
            o.mb = i | ld | st; o.rm_en = st;
        end
        if (md) begin
            o.alu = alu; o.rz1_en = 1'b1; o.rlo_en = 1'b1;
        end
        if (beq) begin
            o.alu = 4'd1; o.rpc_en = z; o.minc = 1'b1; o.mpc = 1'b1;
        end
        if (jr | jal) o.rpc_en = 1'b1;
        push(o, rb(), rb(), beq ? z : rb());
        if (beq | jr | md) return;
        if (ld | st) begin
            for (int k = 0; k < mw; k++) begin
                o = '0; o.mrd = ld; o.mwr = st;
                push(o, rb(), 1'b0, rb());
            end
            o = '0; o.mrd = ld; o.mwr = st;
            if (ld) begin
                o.ry_en = 1'b1; o.my = 3'd2;
            end
            push(o, rb(), 1'b1, rb());
        end else begin
            o = '0; o.ry_en = 1'b1;
            o.my = hi ? 3'd1 : lo ? 3'd3 : jal ? 3'd4 : 3'd0;
            push(o, rb(), rb(), rb());
        end
        if (st) return;
        o = '0; o.rf = 1'b1;
        o.mc = (r | hi | lo) ? 2'd2 : jal ? 2'd3 : 2'd1;
        push(o, rb(), rb(), rb());
    endtask

    // Starts and ends at a falling edge; one queue entry per clock.
    task automatic run_queue(input int limit);
        step_t s;
        int n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            s = q.pop_front();
            bus.iInstrReady = s.ir;
            bus.iMemReady   = s.mr;
            bus.iZero       = s.z;
            #1 chk($sformatf("%s#%0d", cur, n), 32'(obs), 32'(s.e));
            @(negedge clk);
            n++;
        end
        q.delete();
    endtask

    task automatic instr(input logic [4:0] op, input int fw, input int mw,
                         input logic z);
        cur = $sformatf("op%02h_z%0d", op, z);
        bus.iIR = {op, 27'($urandom())};
        model(op, fw, mw, z);
        run_queue(-1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.iInstrReady = rb();
        bus.iMemReady   = rb();
        #1 chk("reset_a", 32'(obs), 32'd0);
        @(negedge clk);
        #1 chk("reset_b", 32'(obs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] op;
        outs_t o;
        bus.iIR = '0;
        bus.iZero = 1'b0;
        bus.iInstrReady = 1'b0;
        bus.iMemReady = 1'b0;
        @(negedge clk);
        do_reset();

        instr(5'd3, 0, 0, 1'b0);
        instr(5'd0, 0, 3, 1'b0);
        instr(5'd18, 0, 0, 1'b1);
        instr(5'd18, 0, 0, 1'b0);
        instr(5'd20, 1, 0, 1'b0);
        instr(5'd31, 0, 0, 1'b0);
        instr(5'd2, 2, 1, 1'b0);
        instr(5'd15, 0, 0, 1'b0);
        instr(5'd10, 0, 0, 1'b0);
        instr(5'd11, 0, 0, 1'b0);
        instr(5'd27, 0, 0, 1'b0);
        do_reset();

        for (int n = 0; n < 250; n++) begin
            op = 5'($urandom_range(0, 31));
            instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
            if (op == 5'd27) do_reset();
        end

        instr(5'd27, 0, 0, 1'b0);
        do_reset();

        cur = "st_rst";
        bus.iIR = {5'd2, 27'($urandom())};
        model(5'd2, 0, 8, 1'b0);
        run_queue(5);
        bus.iMemReady = 1'b0;
        o = '0; o.mwr = 1'b1;
        #1 chk("st_wait", 32'(obs), 32'(o));
        #2 rst = 1'b1;
        #1 chk("st_rst_drop", 32'(obs), 32'd0);
        @(negedge clk);
        #1 chk("st_rst_hold", 32'(obs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        instr(5'd7, 0, 0, 1'b0);
        instr(5'd19, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the processor datapath. It decodes the instruction register and drives every register enable, mux select, ALU opcode and register-file write strobe. It also runs the ready/strobe handshakes with instruction memory and data memory. The block sits beside the datapath and replaces hand-driven control in benches; the datapath's register contents and ALU flag are its only inputs besides the two ready lines.

## Interface
- No parameters.
- iClk  in  1  clock; all state changes on rising edge
- iRst  in  1  asynchronous, active-high reset
- iIR  in  32  instruction register contents: opcode [31:27], field A [26:23], field B [22:19], field C [18:15], imm [18:0]
- iZero  in  1  ALU zero flag
- iInstrReady  in  1  instruction memory data valid
- iMemReady  in  1  data memory access complete
- oIrEn, oRaEn, oRbEn, oRz0En, oRz1En, oRloEn, oRmEn, oRyEn, oRpcEn, oRpcTempEn  out  1 each  datapath register enables
- oMbSel  out  1  0=RB, 1=imm
- oMincSel  out  1  0=+4, 1=imm
- oMpcSel  out  1  0=RA, 1=PC adder
- oMySel  out  3  0=rz0, 1=HI(rz1), 2=memory, 3=LO, 4=pc_temp
- oMcSel  out  2  write address: 0=A, 1=B, 2=C, 3=r15
- oAluCtl  out  4  0000 add, 0001 sub, 0010 or, 0011 and, 0100 div, 0101 mul
- oRfWrite  out  1  register-file write
- oInstrRead, oMemRead, oMemWrite  out  1 each  memory strobes
- oHalted  out  1  high in HALT
- oIllegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- Instruction set:
  - R-type: add 00011, sub 00100, and 00101, or 00110. R[C] <- R[A] op R[B].
  - I-type: addi 00111, andi 01000, ori 01001. R[B] <- R[A] op imm.
  - ld 00000: R[B] <- M[R[A]+imm].
  - st 00010: M[R[A]+imm] <- R[B].
  - mul 01111, div 10000: HI/LO <- R[A] op R[B]. No GPR write.
  - mfhi 01010: R[C] <- HI. mflo 01011: R[C] <- LO.
  - beq 10010: if R[A]==R[B], PC <- PC+4+imm.
  - jr 10011: PC <- R[A].
  - jal 10100: r15 <- PC+4, then PC <- R[A].
  - nop 11010. halt 11011.
- State FETCH:
  - Assert oInstrRead.
  - Stay while iInstrReady=0.
  - On iInstrReady=1, assert oIrEn and go to DECODE.
- State DECODE:
  - Assert oRaEn and oRbEn.
  - Assert oRpcEn with oMincSel=0, oMpcSel=1, so PC <- PC+4.
  - Undefined opcode: pulse oIllegal, go to FETCH. It executes as a nop.
  - halt goes to HALT. nop goes to FETCH. Everything else goes to EXECUTE.
- State EXECUTE:
  - Always assert oRpcTempEn (captures PC+4).
  - R-type, ld, st, I-type: oAluCtl per op and oRz0En. oMbSel=1 for I-type, ld and st.
  - st additionally asserts oRmEn.
  - mul/div: oRz1En and oRloEn.
  - beq: oAluCtl=sub. oRpcEn=iZero, with oMincSel=1, oMpcSel=1.
  - jr and jal: oRpcEn with oMpcSel=0.
  - beq, jr, mul and div then go to FETCH. All others go to MEMORY.
- State MEMORY:
  - ld holds oMemRead until iMemReady=1. In that cycle assert oRyEn with oMySel=2.
  - st holds oMemWrite until iMemReady=1, then goes to FETCH.
  - Other ops assert oRyEn in one cycle. oMySel is 0 for ALU ops, 1 for mfhi, 3 for mflo, 4 for jal.
  - All except st then go to WRITEBACK.
- State WRITEBACK:
  - Assert oRfWrite. oMcSel is 2 for R-type, mfhi and mflo; 1 for I-type and ld; 3 for jal.
  - Go to FETCH.
- State HALT: absorbing until iRst. oHalted=1, all other outputs 0.

## Timing
- Reset: iRst high forces state FETCH and every output to 0, including the strobes, regardless of clock.
- After iRst falls, the first FETCH cycle asserts oInstrRead.
- Outputs are combinational from the state register and iIR. Only one state is active per cycle, and no enable is asserted outside the states listed above.
- Latency with zero-wait memories:
  - ALU, ld, mfhi/mflo, jal: 5 cycles.
  - st: 4 cycles.
  - beq, jr, mul, div: 3 cycles.
  - nop and illegal: 2 cycles.
  - halt enters HALT after 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Strobes stay stable and asserted through a wait. A ready arriving in a state that does not use it is ignored.
- iZero is sampled only in the EXECUTE cycle of beq.
- iRst during a memory wait drops the strobe immediately. No register or memory write is issued afterwards.

## Test plan
- Reset, then add with iInstrReady high from the first cycle:
  - oIrEn asserted in cycle 1.
  - oRfWrite=1 with oMcSel=2 in cycle 5.
  - Next oInstrRead in cycle 6.
- ld with iMemReady held low 3 cycles:
  - oMemRead high for 4 cycles.
  - oRyEn only in the last of them, with oMySel=2.
  - oRfWrite with oMcSel=1 on the next cycle.
- beq:
  - With iZero=1, oRpcEn=1, oMincSel=1 in EXECUTE.
  - With iZero=0, oRpcEn=0.
  - Both return to FETCH after 3 cycles; oRfWrite is never asserted.
- jal: oMpcSel=0 with oRpcEn in EXECUTE; oMySel=4 in MEMORY; oMcSel=3 in WRITEBACK.
- Opcode 11111 pulses oIllegal for exactly 1 cycle in DECODE, then FETCH.
- halt sets oHalted=1 indefinitely. Then assert iRst mid-st-wait: oMemWrite drops in the same cycle, and the next instruction after release starts in FETCH.
